// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / bypass-select control for a 5-stage MIPS-style pipeline.
// Tracks E/M/W stage records {A1, A2, A3, Tnew} and compares them with the
// D-stage sources using Tuse/Tnew timing.
// Optional feature macro: HAZARD_FWD_EN
//   defined   -> Tuse/Tnew based stalling with full bypass selection
//   undefined -> no bypassing; stall on any pending write to a used source
// D_op class codes:
//   NOP=0  ADD=1  SUB=2  AND=3  OR=4  SLT=5  SLTU=6  ADDI=7  ANDI=8  ORI=9
//   LUI=10 LB=11  LH=12  LW=13  SB=14 SH=15  SW=16   BEQ=17  BNE=18  JAL=19
//   JR=20  MULT=21 MULTU=22 DIV=23 DIVU=24 MFHI=25 MFLO=26 MTHI=27 MTLO=28
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] D_op,
  input  logic [4:0] D_A1,
  input  logic [4:0] D_A2,
  input  logic [4:0] D_A3,
  input  logic       md_busy,
  output logic       stall,
  output logic [1:0] FwdD_rs,
  output logic [1:0] FwdD_rt,
  output logic [1:0] FwdE_rs,
  output logic [1:0] FwdE_rt,
  output logic [1:0] FwdM_rt
);

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB   = 6'd2,  OP_AND  = 6'd3,
    OP_OR   = 6'd4,  OP_SLT  = 6'd5,  OP_SLTU  = 6'd6,  OP_ADDI = 6'd7,
    OP_ANDI = 6'd8,  OP_ORI  = 6'd9,  OP_LUI   = 6'd10, OP_LB   = 6'd11,
    OP_LH   = 6'd12, OP_LW   = 6'd13, OP_SB    = 6'd14, OP_SH   = 6'd15,
    OP_SW   = 6'd16, OP_BEQ  = 6'd17, OP_BNE   = 6'd18, OP_JAL  = 6'd19,
    OP_JR   = 6'd20, OP_MULT = 6'd21, OP_MULTU = 6'd22, OP_DIV  = 6'd23,
    OP_DIVU = 6'd24, OP_MFHI = 6'd25, OP_MFLO  = 6'd26, OP_MTHI = 6'd27,
    OP_MTLO = 6'd28
  } op_e;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic [1:0] tnew;
  } rec_t;

  rec_t       r_e, r_m, r_w;
  rec_t       w_d_rec;
  op_e        w_op;
  logic       w_rs_en, w_rt_en, w_md_op, w_writes;
  logic [1:0] w_rs_tuse, w_rt_tuse, w_tnew;
  logic       w_stall_rs, w_stall_rt, w_stall_md;
  logic       w_unused;

  assign w_op = op_e'(D_op);

  // Record one stage further down the pipe: Tnew counts down, floor at 0.
  function automatic rec_t age(input rec_t r);
    age = r;
    if (r.tnew != 2'd0) age.tnew = r.tnew - 2'd1;
  endfunction

`ifdef HAZARD_FWD_EN
  // Producer still too far from its result for the consumer's Tuse.
  function automatic logic src_stall(input logic en, input logic [1:0] tuse,
                                     input logic [4:0] a, input rec_t e, input rec_t m);
    return en && (a != '0) &&
           (((e.a3 == a) && (e.tnew > tuse)) || ((m.a3 == a) && (m.tnew > tuse)));
  endfunction

  // D-stage bypass: E (PC+8 of JAL) beats M.
  function automatic logic [1:0] fwd_d(input logic [4:0] a, input rec_t e, input rec_t m);
    if ((a != '0) && (e.a3 == a) && (e.tnew == 2'd0))      return 2'd3;
    else if ((a != '0) && (m.a3 == a) && (m.tnew == 2'd0)) return 2'd1;
    else                                                   return 2'd0;
  endfunction

  // E-stage bypass: M result beats W result.
  function automatic logic [1:0] fwd_e(input logic [4:0] a, input rec_t m, input rec_t w);
    if ((a != '0) && (m.a3 == a) && (m.tnew == 2'd0)) return 2'd1;
    else if ((a != '0) && (w.a3 == a))                return 2'd2;
    else                                              return 2'd0;
  endfunction
`else
  // Without bypassing any in-flight writer of a used source blocks D.
  function automatic logic src_stall(input logic en, input logic [4:0] a,
                                     input rec_t e, input rec_t m, input rec_t w);
    return en && (a != '0) && ((e.a3 == a) || (m.a3 == a) || (w.a3 == a));
  endfunction
`endif

  // Decode D_op into source timing, result latency and writer/md class.
  always_comb begin
    w_rs_en   = 1'b0;
    w_rt_en   = 1'b0;
    w_rs_tuse = 2'd0;
    w_rt_tuse = 2'd0;
    w_tnew    = 2'd0;
    w_writes  = 1'b0;
    w_md_op   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLTU: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd1;
        w_rt_en = 1'b1; w_rt_tuse = 2'd1;
        w_writes = 1'b1; w_tnew = 2'd1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd1;
        w_writes = 1'b1; w_tnew = 2'd1;
      end
      OP_LUI: begin
        w_writes = 1'b1; w_tnew = 2'd1;
      end
      OP_LB, OP_LH, OP_LW: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd1;
        w_writes = 1'b1; w_tnew = 2'd2;
      end
      OP_SB, OP_SH, OP_SW: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd1;
        w_rt_en = 1'b1; w_rt_tuse = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd0;
        w_rt_en = 1'b1; w_rt_tuse = 2'd0;
      end
      OP_JAL: begin
        w_writes = 1'b1; w_tnew = 2'd0;
      end
      OP_JR: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd0;
      end
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd1;
        w_rt_en = 1'b1; w_rt_tuse = 2'd1;
        w_md_op = 1'b1;
      end
      OP_MFHI, OP_MFLO: begin
        w_writes = 1'b1; w_tnew = 2'd1;
        w_md_op = 1'b1;
      end
      OP_MTHI, OP_MTLO: begin
        w_rs_en = 1'b1; w_rs_tuse = 2'd1;
        w_md_op = 1'b1;
      end
      default: ;
    endcase
  end

  // Record that enters E when D is allowed to advance.
  always_comb begin
    w_d_rec      = '0;
    w_d_rec.a1   = D_A1;
    w_d_rec.a2   = D_A2;
    w_d_rec.a3   = w_writes ? D_A3 : '0;
    w_d_rec.tnew = w_tnew;
  end

  // Stall decision and bypass selects from the stage records.
  always_comb begin
    w_stall_md = md_busy && w_md_op;
`ifdef HAZARD_FWD_EN
    w_stall_rs = src_stall(w_rs_en, w_rs_tuse, D_A1, r_e, r_m);
    w_stall_rt = src_stall(w_rt_en, w_rt_tuse, D_A2, r_e, r_m);
    FwdD_rs    = fwd_d(D_A1, r_e, r_m);
    FwdD_rt    = fwd_d(D_A2, r_e, r_m);
    FwdE_rs    = fwd_e(r_e.a1, r_m, r_w);
    FwdE_rt    = fwd_e(r_e.a2, r_m, r_w);
    // M-stage store data can only be fed from W.
    FwdM_rt    = ((r_m.a2 != '0) && (r_w.a3 == r_m.a2)) ? 2'd2 : 2'd0;
`else
    w_stall_rs = src_stall(w_rs_en, D_A1, r_e, r_m, r_w);
    w_stall_rt = src_stall(w_rt_en, D_A2, r_e, r_m, r_w);
    FwdD_rs    = 2'd0;
    FwdD_rt    = 2'd0;
    FwdE_rs    = 2'd0;
    FwdE_rt    = 2'd0;
    FwdM_rt    = 2'd0;
`endif
    stall = w_stall_rs || w_stall_rt || w_stall_md;
  end

  // Record fields not consumed in every build.
  assign w_unused = ^{r_m.a1, r_w.a1, r_w.a2, r_w.tnew, w_rs_tuse, w_rt_tuse};

  // Advance E/M/W; a stall turns the E slot into a bubble; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= stall ? '0 : w_d_rec;
      r_m <= age(r_e);
      r_w <= age(r_m);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random instruction stream, checked
// every cycle against an instruction-level pipeline model.
module tb_hazard_ctrl;

  localparam int NOP=0, ADD=1, SUB=2, AND_=3, OR_=4, SLT=5, SLTU=6, ADDI=7,
                 ANDI=8, ORI=9, LUI=10, LB=11, LH=12, LW=13, SB=14, SH=15,
                 SW=16, BEQ=17, BNE=18, JAL=19, JR=20, MULT=21, MULTU=22,
                 DIV=23, DIVU=24, MFHI=25, MFLO=26, MTHI=27, MTLO=28;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] D_op = '0;
  logic [4:0] D_A1 = '0, D_A2 = '0, D_A3 = '0;
  logic       md_busy = 1'b0;
  logic       stall;
  logic [1:0] FwdD_rs, FwdD_rt, FwdE_rs, FwdE_rt, FwdM_rt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .D_op(D_op), .D_A1(D_A1), .D_A2(D_A2),
    .D_A3(D_A3), .md_busy(md_busy), .stall(stall), .FwdD_rs(FwdD_rs),
    .FwdD_rt(FwdD_rt), .FwdE_rs(FwdE_rs), .FwdE_rt(FwdE_rt), .FwdM_rt(FwdM_rt)
  );

  int n_chk = 0, n_pass = 0;
  // Model pipeline: index 0 = E, 1 = M, 2 = W (instruction-level view).
  int m_op[3], m_a1[3], m_a2[3], m_a3[3];
  bit m_last_stall;
  logic       obs_st;
  logic [1:0] obs_fdrs, obs_fdrt, obs_fers, obs_fert, obs_fmrt;

  function automatic int tuse_rs(int op);
    if (op == BEQ || op == BNE || op == JR) return 0;
    if ((op >= ADD && op <= ORI) || (op >= LB && op <= SW) ||
        (op >= MULT && op <= DIVU) || op == MTHI || op == MTLO) return 1;
    return -1;
  endfunction

  function automatic int tuse_rt(int op);
    if (op == BEQ || op == BNE) return 0;
    if ((op >= ADD && op <= SLTU) || (op >= MULT && op <= DIVU)) return 1;
    if (op >= SB && op <= SW) return 2;
    return -1;
  endfunction

  function automatic int latency(int op);
    if (op >= LB && op <= LW) return 2;
    if ((op >= ADD && op <= LUI) || op == MFHI || op == MFLO) return 1;
    return 0;
  endfunction

  function automatic bit writes(int op);
    return (op >= ADD && op <= LW) || op == JAL || op == MFHI || op == MFLO;
  endfunction

  function automatic int tnew_at(int s);
    int t;
    t = latency(m_op[s]) - s;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic logic [1:0] exp_fwd_late(int a);
    if (FWD && a != 0 && m_a3[1] == a && tnew_at(1) == 0) return 2'd1;
    if (FWD && a != 0 && m_a3[2] == a) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      m_op[s] = 0; m_a1[s] = 0; m_a2[s] = 0; m_a3[s] = 0;
    end
    m_last_stall = 1'b0;
  endtask

  // One cycle: drive D, sample outputs, compare with model, advance model.
  task automatic step(input int op, input int a1, input int a2, input int a3,
                      input bit busy, input bit rst);
    int srcs[2], tus[2];
    bit est;
    logic [1:0] efd[2];
    logic [1:0] efm;
    @(negedge clk);
    D_op = op[5:0]; D_A1 = a1[4:0]; D_A2 = a2[4:0]; D_A3 = a3[4:0];
    md_busy = busy; reset = rst;
    #1;
    obs_st = stall; obs_fdrs = FwdD_rs; obs_fdrt = FwdD_rt;
    obs_fers = FwdE_rs; obs_fert = FwdE_rt; obs_fmrt = FwdM_rt;
    srcs[0] = a1; srcs[1] = a2;
    tus[0] = tuse_rs(op); tus[1] = tuse_rt(op);
    est = busy && (op >= MULT && op <= MTLO);
    for (int k = 0; k < 2; k++) begin
      efd[k] = 2'd0;
      if (srcs[k] != 0) begin
        if (FWD) begin
          if (tus[k] >= 0)
            for (int s = 0; s < 2; s++)
              if (m_a3[s] == srcs[k] && tnew_at(s) > tus[k]) est = 1'b1;
          if (m_a3[0] == srcs[k] && tnew_at(0) == 0) efd[k] = 2'd3;
          else if (m_a3[1] == srcs[k] && tnew_at(1) == 0) efd[k] = 2'd1;
        end else begin
          if (tus[k] >= 0)
            for (int s = 0; s < 3; s++)
              if (m_a3[s] == srcs[k]) est = 1'b1;
        end
      end
    end
    efm = (FWD && m_a2[1] != 0 && m_a3[2] == m_a2[1]) ? 2'd2 : 2'd0;
    chk("stall", {7'd0, obs_st}, {7'd0, est});
    chk("FwdD_rs", {6'd0, obs_fdrs}, {6'd0, efd[0]});
    chk("FwdD_rt", {6'd0, obs_fdrt}, {6'd0, efd[1]});
    chk("FwdE_rs", {6'd0, obs_fers}, {6'd0, exp_fwd_late(m_a1[0])});
    chk("FwdE_rt", {6'd0, obs_fert}, {6'd0, exp_fwd_late(m_a2[0])});
    chk("FwdM_rt", {6'd0, obs_fmrt}, {6'd0, efm});
    if (rst) begin
      model_clear();
    end else begin
      for (int s = 2; s > 0; s--) begin
        m_op[s] = m_op[s-1]; m_a1[s] = m_a1[s-1];
        m_a2[s] = m_a2[s-1]; m_a3[s] = m_a3[s-1];
      end
      if (est) begin
        m_op[0] = 0; m_a1[0] = 0; m_a2[0] = 0; m_a3[0] = 0;
      end else begin
        m_op[0] = op; m_a1[0] = a1; m_a2[0] = a2;
        m_a3[0] = writes(op) ? a3 : 0;
      end
      m_last_stall = est;
    end
  endtask

  // Re-present an instruction while the DUT stalls; bounded to 8 cycles.
  task automatic hold(input int op, input int a1, input int a2, input int a3,
                      output int nst);
    nst = 0;
    for (int i = 0; i < 8; i++) begin
      step(op, a1, a2, a3, 1'b0, 1'b0);
      if (obs_st !== 1'b1) break;
      nst++;
    end
  endtask

  task automatic flush();
    repeat (3) step(NOP, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int cop, ca1, ca2, ca3;
    bit cbusy, crst;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();

    // Idle after reset
    step(NOP, 0, 0, 0, 1'b0, 1'b0);
    chk("reset_stall", {7'd0, obs_st}, 8'd0);
    chk("reset_fwd", {obs_fdrs, obs_fdrt, obs_fers, obs_fert}, 8'd0);

    // lw $1 ; add $2,$1,$3
    step(LW, 2, 1, 1, 1'b0, 1'b0);
    hold(ADD, 1, 3, 2, n);
    chk("lw_use_stalls", n[7:0], FWD ? 8'd1 : 8'd3);
    step(NOP, 0, 0, 0, 1'b0, 1'b0);
    chk("lw_use_FwdE_rs", {6'd0, obs_fers}, FWD ? 8'd2 : 8'd0);
    flush();

    // add $1,$2,$3 ; beq $1,$1
    step(ADD, 2, 3, 1, 1'b0, 1'b0);
    hold(BEQ, 1, 1, 0, n);
    chk("add_beq_stalls", n[7:0], FWD ? 8'd1 : 8'd3);
    chk("add_beq_FwdD_rs", {6'd0, obs_fdrs}, FWD ? 8'd1 : 8'd0);
    chk("add_beq_FwdD_rt", {6'd0, obs_fdrt}, FWD ? 8'd1 : 8'd0);
    flush();

    // jal ; jr $31
    step(JAL, 0, 0, 31, 1'b0, 1'b0);
    hold(JR, 31, 0, 0, n);
    chk("jal_jr_stalls", n[7:0], FWD ? 8'd0 : 8'd3);
    chk("jal_jr_FwdD_rs", {6'd0, obs_fdrs}, FWD ? 8'd3 : 8'd0);
    flush();

    // lw $0 ; add $4,$0,$0
    step(LW, 0, 0, 0, 1'b0, 1'b0);
    hold(ADD, 0, 0, 4, n);
    chk("zero_reg_stalls", n[7:0], 8'd0);
    chk("zero_reg_fwd", {obs_fdrs, obs_fdrt, obs_fers, obs_fert}, 8'd0);
    flush();

    // mult ; mflo with md_busy high five cycles
    step(MULT, 1, 2, 0, 1'b0, 1'b0);
    n = 0;
    repeat (5) begin
      step(MFLO, 0, 0, 5, 1'b1, 1'b0);
      if (obs_st === 1'b1) n++;
    end
    chk("md_busy_stalls", n[7:0], 8'd5);
    step(MFLO, 0, 0, 5, 1'b0, 1'b0);
    chk("md_idle_stall", {7'd0, obs_st}, 8'd0);
    flush();

    // reset in the middle of the load-use stall
    step(LW, 2, 1, 1, 1'b0, 1'b0);
    step(ADD, 1, 3, 2, 1'b0, 1'b1);
    chk("mid_stall_before_reset", {7'd0, obs_st}, 8'd1);
    step(ADD, 1, 3, 2, 1'b0, 1'b0);
    chk("after_reset_stall", {7'd0, obs_st}, 8'd0);
    chk("after_reset_fwd", {obs_fdrs, obs_fdrt, obs_fers, obs_fert}, 8'd0);
    chk("after_reset_fwdm", {6'd0, obs_fmrt}, 8'd0);
    flush();

    // Random instruction stream; stalled instructions are re-presented.
    cop = NOP; ca1 = 0; ca2 = 0; ca3 = 0;
    repeat (800) begin
      if (!m_last_stall) begin
        cop = $urandom_range(0, 28);
        ca1 = $urandom_range(0, 3);
        ca2 = $urandom_range(0, 3);
        ca3 = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 3);
      end
      cbusy = ($urandom_range(0, 3) == 0);
      crst  = ($urandom_range(0, 59) == 0);
      step(cop, ca1, ca2, ca3, cbusy, crst);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
